// File: rtl/spi_lcd_panel_rx.sv
// Responder end of a 4-wire LCD SPI link: oversampled deserialiser, command/parameter
// decode, CASET/RASET window tracking and RAMWR RGB444 unpacking into addressed pixel writes.
module spi_lcd_panel_rx #(
    parameter int H_RES = 80,
    parameter int V_RES = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LCD_CSX,
    input  logic        LCD_DC,
    input  logic        LCD_SCK,
    input  logic        LCD_SDA,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        param_valid,
    output logic [7:0]  param_byte,
    output logic [3:0]  param_idx,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [11:0] pix_data,
    output logic        frame_done
);

    localparam logic [7:0] XE_RST = 8'(H_RES - 1);
    localparam logic [7:0] YE_RST = 8'(V_RES - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_OTHER, ST_CASET, ST_RASET, ST_RAMWR} state_t;

    logic       csx_s1_r, csx_s2_r, csx_prev_r;
    logic       dc_s1_r, dc_s2_r;
    logic       sck_s1_r, sck_s2_r, sck_prev_r;
    logic       sda_s1_r, sda_s2_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       byte_stb_r;
    logic [7:0] byte_r;
    logic       byte_dc_r;

    state_t     state_r, state_s;
    logic [7:0] xs_r, xe_r, ys_r, ye_r, x_r, y_r, hold_r;
    logic [7:0] xs_s, xe_s, ys_s, ye_s, x_s, y_s, hold_s;
    logic [1:0] phase_r, phase_s;
    logic [3:0] idx_cnt_r, idx_cnt_s;
    logic        cmd_valid_s, param_valid_s, pix_valid_s, frame_done_s, emit_s;
    logic [7:0]  cmd_byte_s, param_byte_s, pix_x_s, pix_y_s;
    logic [3:0]  param_idx_s;
    logic [11:0] pix_data_s, emit_data_s;

    logic sck_rise_s;
    logic csx_live_s;

    assign sck_rise_s = sck_s2_r & ~sck_prev_r;
    // A byte whose last SCK edge coincides with CSX release is still taken.
    assign csx_live_s = ~csx_s2_r | ~csx_prev_r;

    // Two-flop synchronisers plus edge-detect history for the bus pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csx_s1_r <= 1'b1; csx_s2_r <= 1'b1; csx_prev_r <= 1'b1;
            dc_s1_r  <= 1'b0; dc_s2_r  <= 1'b0;
            sck_s1_r <= 1'b0; sck_s2_r <= 1'b0; sck_prev_r <= 1'b0;
            sda_s1_r <= 1'b0; sda_s2_r <= 1'b0;
        end else begin
            csx_s1_r <= LCD_CSX; csx_s2_r <= csx_s1_r; csx_prev_r <= csx_s2_r;
            dc_s1_r  <= LCD_DC;  dc_s2_r  <= dc_s1_r;
            sck_s1_r <= LCD_SCK; sck_s2_r <= sck_s1_r; sck_prev_r <= sck_s2_r;
            sda_s1_r <= LCD_SDA; sda_s2_r <= sda_s1_r;
        end
    end

    // Deserialiser: MSB-first shift, byte strobe on the eighth bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            byte_stb_r <= 1'b0;
            byte_r     <= 8'd0;
            byte_dc_r  <= 1'b0;
        end else begin
            byte_stb_r <= 1'b0;
            if (sck_rise_s && csx_live_s) begin
                shift_r <= {shift_r[6:0], sda_s2_r};
                if (bit_cnt_r == 3'd7) begin
                    byte_stb_r <= 1'b1;
                    byte_r     <= {shift_r[6:0], sda_s2_r};
                    byte_dc_r  <= dc_s2_r;
                end
                bit_cnt_r <= csx_s2_r ? 3'd0 : bit_cnt_r + 3'd1;
            end else if (csx_s2_r) begin
                bit_cnt_r <= 3'd0;
            end
        end
    end

    // Decoder next-state: command dispatch, window capture, pixel packing and addressing.
    always_comb begin
        state_s       = state_r;
        xs_s          = xs_r;
        xe_s          = xe_r;
        ys_s          = ys_r;
        ye_s          = ye_r;
        x_s           = x_r;
        y_s           = y_r;
        hold_s        = hold_r;
        phase_s       = phase_r;
        idx_cnt_s     = idx_cnt_r;
        cmd_valid_s   = 1'b0;
        cmd_byte_s    = cmd_byte;
        param_valid_s = 1'b0;
        param_byte_s  = param_byte;
        param_idx_s   = param_idx;
        pix_valid_s   = 1'b0;
        pix_x_s       = pix_x;
        pix_y_s       = pix_y;
        pix_data_s    = pix_data;
        frame_done_s  = 1'b0;
        emit_s        = 1'b0;
        emit_data_s   = 12'h000;

        if (byte_stb_r && !byte_dc_r) begin
            cmd_valid_s = 1'b1;
            cmd_byte_s  = byte_r;
            param_idx_s = 4'd0;
            idx_cnt_s   = 4'd0;
            phase_s     = 2'd0;
            case (byte_r)
                8'h2A:   state_s = ST_CASET;
                8'h2B:   state_s = ST_RASET;
                8'h2C: begin
                    state_s = ST_RAMWR;
                    x_s     = xs_r;
                    y_s     = ys_r;
                end
                default: state_s = ST_OTHER;
            endcase
        end else if (byte_stb_r) begin
            param_valid_s = 1'b1;
            param_byte_s  = byte_r;
            param_idx_s   = idx_cnt_r;
            idx_cnt_s     = (idx_cnt_r == 4'd15) ? 4'd15 : idx_cnt_r + 4'd1;
            case (state_r)
                ST_CASET: begin
                    if (idx_cnt_r == 4'd1)      xs_s = byte_r;
                    else if (idx_cnt_r == 4'd3) xe_s = byte_r;
                    else                        xs_s = xs_r;
                end
                ST_RASET: begin
                    if (idx_cnt_r == 4'd1)      ys_s = byte_r;
                    else if (idx_cnt_r == 4'd3) ye_s = byte_r;
                    else                        ys_s = ys_r;
                end
                ST_RAMWR: begin
                    case (phase_r)
                        2'd0: begin
                            hold_s  = byte_r;
                            phase_s = 2'd1;
                        end
                        2'd1: begin
                            emit_s      = 1'b1;
                            emit_data_s = {hold_r, byte_r[7:4]};
                            hold_s      = {4'h0, byte_r[3:0]};
                            phase_s     = 2'd2;
                        end
                        2'd2: begin
                            emit_s      = 1'b1;
                            emit_data_s = {hold_r[3:0], byte_r};
                            phase_s     = 2'd0;
                        end
                        default: phase_s = 2'd0;
                    endcase
                end
                default: state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end

        if (emit_s) begin
            pix_valid_s = 1'b1;
            pix_x_s     = x_r;
            pix_y_s     = y_r;
            pix_data_s  = emit_data_s;
            if (x_r != xe_r) begin
                x_s = x_r + 8'd1;
            end else begin
                x_s = xs_r;
                if (y_r != ye_r) begin
                    y_s = y_r + 8'd1;
                end else begin
                    y_s          = ys_r;
                    frame_done_s = 1'b1;
                end
            end
        end else begin
            pix_valid_s = 1'b0;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            xs_r        <= 8'd0;
            xe_r        <= XE_RST;
            ys_r        <= 8'd0;
            ye_r        <= YE_RST;
            x_r         <= 8'd0;
            y_r         <= 8'd0;
            hold_r      <= 8'd0;
            phase_r     <= 2'd0;
            idx_cnt_r   <= 4'd0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'd0;
            param_valid <= 1'b0;
            param_byte  <= 8'd0;
            param_idx   <= 4'd0;
            pix_valid   <= 1'b0;
            pix_x       <= 8'd0;
            pix_y       <= 8'd0;
            pix_data    <= 12'd0;
            frame_done  <= 1'b0;
        end else begin
            state_r     <= state_s;
            xs_r        <= xs_s;
            xe_r        <= xe_s;
            ys_r        <= ys_s;
            ye_r        <= ye_s;
            x_r         <= x_s;
            y_r         <= y_s;
            hold_r      <= hold_s;
            phase_r     <= phase_s;
            idx_cnt_r   <= idx_cnt_s;
            cmd_valid   <= cmd_valid_s;
            cmd_byte    <= cmd_byte_s;
            param_valid <= param_valid_s;
            param_byte  <= param_byte_s;
            param_idx   <= param_idx_s;
            pix_valid   <= pix_valid_s;
            pix_x       <= pix_x_s;
            pix_y       <= pix_y_s;
            pix_data    <= pix_data_s;
            frame_done  <= frame_done_s;
        end
    end

endmodule
